hps_fpga_ocm_stream_reader: RTL and testbench

//  Read-side consumer of the 8192 x 64-bit on-chip RAM (1-cycle read latency, unregistered q).
//  On a start command it reads length consecutive words from base_addr and emits them
//  as an Avalon-ST source with backpressure, sop/eop framing and a done pulse.

---
 rtl/hps_fpga_ocm_pkg.sv | 20 ++
 rtl/hps_fpga_ocm_skid_fifo.sv | 48 ++++
 rtl/hps_fpga_ocm_stream_reader.sv | 134 +++++++++++++
 tb/tb_hps_fpga_ocm_stream_reader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_fpga_ocm_pkg.sv
// Shared widths, RAM depth and FSM encoding for the on-chip RAM stream reader.
package hps_fpga_ocm_pkg;

   localparam int ADDR_W    = 13;
   localparam int DATA_W    = 64;
   localparam int LEN_W     = 14;
   localparam int OCM_DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // A job can never usefully cover more than the whole RAM once.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return (len > LEN_W'(OCM_DEPTH)) ? LEN_W'(OCM_DEPTH) : len;
   endfunction

endpackage

// File: rtl/hps_fpga_ocm_skid_fifo.sv
// Two-entry skid FIFO holding {data, sop, eop}; absorbs the RAM read pipeline under backpressure.
module hps_fpga_ocm_skid_fifo
   import hps_fpga_ocm_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W+1:0] push_entry,
   input  logic              pop,
   output logic [DATA_W+1:0] head_entry,
   output logic [1:0]        count
);

   logic [DATA_W+1:0] mem_q [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; an entry is only observable once count covers it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   assign head_entry = mem_q[rd_ptr_q];
   assign count      = count_q;

endmodule

// File: rtl/hps_fpga_ocm_stream_reader.sv
// Reads a block of on-chip RAM words and emits them as a framed Avalon-ST stream with backpressure.
module hps_fpga_ocm_stream_reader
   import hps_fpga_ocm_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sop,
   output logic              out_eop
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic              first_q, first_d;
   logic              inflight_q, inflight_d;
   logic              infl_sop_q, infl_sop_d;
   logic              infl_eop_q, infl_eop_d;
   logic              done_q, done_d;

   logic [LEN_W-1:0]  start_len;
   logic [DATA_W+1:0] head_entry;
   logic [1:0]        fifo_count;
   logic [2:0]        occupancy;
   logic              pop, issue, last_issue;

   assign pop        = out_valid & out_ready;
   // Words already committed to the FIFO after this cycle's pop; a new read needs a free slot.
   assign occupancy  = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
   assign start_len  = clamp_len(length);
   assign last_issue = (rem_q == LEN_W'(1));

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      cur_d   = cur_q;
      rem_d   = rem_q;
      first_d = first_q;
      done_d  = 1'b0;
      issue   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (start_len != '0) begin
                  state_d = RUN;
                  cur_d   = base_addr;
                  rem_d   = start_len;
                  first_d = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (occupancy < 3'd2) begin
               issue   = 1'b1;
               cur_d   = cur_q + ADDR_W'(1);
               rem_d   = rem_q - LEN_W'(1);
               first_d = 1'b0;
               if (last_issue) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && head_entry[0]) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      inflight_d = issue;
      infl_sop_d = issue & first_q;
      infl_eop_d = issue & last_issue;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cur_q      <= '0;
         rem_q      <= '0;
         first_q    <= 1'b0;
         inflight_q <= 1'b0;
         infl_sop_q <= 1'b0;
         infl_eop_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         rem_q      <= rem_d;
         first_q    <= first_d;
         inflight_q <= inflight_d;
         infl_sop_q <= infl_sop_d;
         infl_eop_q <= infl_eop_d;
         done_q     <= done_d;
      end
   end

   // RAM q is valid the cycle after issue, so the in-flight tags line up with mem_readdata.
   hps_fpga_ocm_skid_fifo u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (inflight_q),
      .push_entry ({mem_readdata, infl_sop_q, infl_eop_q}),
      .pop        (pop),
      .head_entry (head_entry),
      .count      (fifo_count)
   );

   assign busy           = (state_q != IDLE);
   assign done           = done_q;
   assign mem_address    = cur_q;
   assign mem_chipselect = issue;
   assign mem_write      = 1'b0;
   assign mem_clken      = 1'b1;
   assign out_valid      = (fifo_count != 2'd0);
   assign out_data       = head_entry[DATA_W+1:2];
   assign out_sop        = out_valid & head_entry[1];
   assign out_eop        = out_valid & head_entry[0];

endmodule

// File: tb/tb_hps_fpga_ocm_stream_reader.sv
// Self-checking bench: table of directed jobs plus hand-written backpressure, busy-start and reset sequences.
module tb_hps_fpga_ocm_stream_reader;

   logic        clk;
   logic        reset;
   logic        start;
   logic [12:0] base_addr;
   logic [13:0] length;
   logic        busy;
   logic        done;
   logic [12:0] mem_address;
   logic        mem_chipselect;
   logic        mem_write;
   logic        mem_clken;
   logic [63:0] mem_readdata;
   logic [63:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_sop;
   logic        out_eop;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   typedef struct {
      logic [12:0] base;
      logic [13:0] len;
      int          exp_beats;
      int          exp_done;
      logic [12:0] exp_last;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      int          cyc;
   } beat_t;

   typedef struct {
      logic [12:0] addr;
      int          cyc;
   } iss_t;

   vec_t  vecs [7];
   beat_t beats [$];
   iss_t  issues [$];
   int    dones [$];

   hps_fpga_ocm_stream_reader dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .base_addr      (base_addr),
      .length         (length),
      .busy           (busy),
      .done           (done),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_sop        (out_sop),
      .out_eop        (out_eop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] word_of(input logic [12:0] a);
      return {16'hBEEF, 3'b000, a, 16'hF00D, 3'b000, a};
   endfunction

   // RAM model: address registered on the clock, q valid the following cycle.
   initial mem_readdata = '0;
   always @(posedge clk) begin
      if (mem_clken && mem_chipselect && !mem_write) mem_readdata <= word_of(mem_address);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor samples at the falling edge, mid-cycle, when inputs and outputs are both settled.
   logic        prev_stall = 1'b0;
   logic [63:0] prev_data;
   logic        prev_sop, prev_eop;
   always @(negedge clk) begin
      if (prev_stall) begin
         check("stall_data_hold", out_data, prev_data);
         check("stall_flags_hold", {61'b0, out_valid, out_sop, out_eop}, {61'b0, 1'b1, prev_sop, prev_eop});
      end
      prev_stall = out_valid && !out_ready && !reset;
      prev_data  = out_data;
      prev_sop   = out_sop;
      prev_eop   = out_eop;
      if (!reset) begin
         if (mem_chipselect) issues.push_back('{mem_address, cyc});
         if (out_valid && out_ready) beats.push_back('{out_data, out_sop, out_eop, cyc});
         if (done) dones.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      beats.delete();
      issues.delete();
      dones.delete();
   endtask

   task automatic launch(input logic [12:0] b, input logic [13:0] l, output int s0);
      start     = 1'b1;
      base_addr = b;
      length    = l;
      s0        = cyc;
      tick();
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      int k;
      k = 0;
      while (dones.size() == 0 && k < bound) begin
         tick();
         k++;
      end
      check({tag, "_done_in_bound"}, 64'(dones.size() != 0), 64'd1);
      tick();
      tick();
   endtask

   task automatic verify(input string tag, input logic [12:0] base, input int n,
                         input int done_off, input int s0, input bit timed);
      int          data_errs, flag_errs, time_errs, addr_errs;
      logic [12:0] a;
      data_errs = 0;
      flag_errs = 0;
      time_errs = 0;
      addr_errs = 0;
      check({tag, "_beats"}, beats.size(), n);
      check({tag, "_issues"}, issues.size(), n);
      foreach (beats[i]) begin
         a = base + 13'(i);
         if (beats[i].data !== word_of(a)) data_errs++;
         if (beats[i].sop !== (i == 0) || beats[i].eop !== (i == n - 1)) flag_errs++;
         if (timed && beats[i].cyc != s0 + 3 + i) time_errs++;
      end
      foreach (issues[i]) begin
         a = base + 13'(i);
         if (issues[i].addr !== a) addr_errs++;
         if (timed && issues[i].cyc != s0 + 1 + i) time_errs++;
      end
      check({tag, "_data_errs"}, data_errs, 0);
      check({tag, "_sop_eop_errs"}, flag_errs, 0);
      check({tag, "_addr_errs"}, addr_errs, 0);
      check({tag, "_timing_errs"}, time_errs, 0);
      if (timed && beats.size() != 0) check({tag, "_first_valid_cycle"}, beats[0].cyc - s0, 3);
      check({tag, "_done_count"}, dones.size(), 1);
      if (dones.size() != 0 && done_off >= 0) check({tag, "_done_cycle"}, dones[0] - s0, done_off);
      if (dones.size() != 0 && beats.size() != 0)
         check({tag, "_done_after_eop"}, dones[0], beats[$].cyc + 1);
      check({tag, "_idle_after"}, {62'b0, busy, out_valid}, 64'd0);
      check({tag, "_mem_ctrl"}, {62'b0, mem_write, mem_clken}, 64'd1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s0;
      int nb;
      string tag;

      //          base      len        beats done   last addr
      vecs[0] = '{13'h0010, 14'd4,    4,    7,    13'h0013};
      vecs[1] = '{13'h1FFE, 14'd4,    4,    7,    13'h0001};
      vecs[2] = '{13'h0100, 14'd1,    1,    4,    13'h0100};
      vecs[3] = '{13'h0200, 14'd0,    0,    1,    13'h0000};
      vecs[4] = '{13'h0ABC, 14'd7,    7,    10,   13'h0AC2};
      vecs[5] = '{13'h1FFF, 14'd2,    2,    5,    13'h0000};
      vecs[6] = '{13'h0123, 14'd9000, 8192, 8195, 13'h0122};

      reset     = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      out_ready = 1'b1;
      repeat (3) tick();
      check("reset_busy_done", {62'b0, busy, done}, 64'd0);
      check("reset_stream", {61'b0, out_valid, out_sop, out_eop}, 64'd0);
      check("reset_mem_ctrl", {61'b0, mem_chipselect, mem_write, mem_clken}, 64'd1);
      check("reset_mem_addr", mem_address, 64'd0);
      reset = 1'b0;
      tick();

      foreach (vecs[v]) begin
         tag = $sformatf("vec%0d", v);
         clear_mon();
         launch(vecs[v].base, vecs[v].len, s0);
         check({tag, "_busy_c1"}, busy, 64'(vecs[v].exp_beats != 0));
         wait_done(tag, vecs[v].exp_beats + 50);
         verify(tag, vecs[v].base, vecs[v].exp_beats, vecs[v].exp_done, s0, 1'b1);
         if (vecs[v].exp_beats != 0 && issues.size() != 0)
            check({tag, "_last_addr"}, issues[$].addr, vecs[v].exp_last);
         repeat (2) tick();
      end

      // Backpressure: ready toggles 0/1, then is held low for 10 cycles.
      clear_mon();
      out_ready = 1'b1;
      launch(13'h0300, 14'd16, s0);
      for (int k = 0; k < 300 && dones.size() == 0; k++) begin
         if (k < 12)      out_ready = (k % 2 == 0) ? 1'b0 : 1'b1;
         else if (k < 22) out_ready = 1'b0;
         else             out_ready = 1'b1;
         if (k == 21) check("bp_issue_bound", 64'((issues.size() - beats.size()) <= 2), 64'd1);
         tick();
      end
      out_ready = 1'b1;
      repeat (2) tick();
      verify("bp", 13'h0300, 16, -1, s0, 1'b0);

      // Start while busy must be ignored.
      clear_mon();
      launch(13'h0400, 14'd6, s0);
      start     = 1'b1;
      base_addr = 13'h0000;
      length    = 14'd3;
      tick();
      tick();
      start     = 1'b0;
      length    = '0;
      wait_done("busy_start", 60);
      repeat (20) tick();
      verify("busy_start", 13'h0400, 6, 9, s0, 1'b1);

      // Reset in the middle of a 16-word job.
      clear_mon();
      launch(13'h0500, 14'd16, s0);
      for (int k = 0; k < 100 && beats.size() < 5; k++) tick();
      check("midrst_reached_beat5", beats.size(), 5);
      reset     = 1'b1;
      out_ready = 1'b0;
      tick();
      check("midrst_busy_done", {62'b0, busy, done}, 64'd0);
      check("midrst_stream", {61'b0, out_valid, out_sop, out_eop}, 64'd0);
      check("midrst_mem", {51'b0, mem_chipselect, mem_address}, 64'd0);
      reset     = 1'b0;
      out_ready = 1'b1;
      nb        = beats.size();
      repeat (30) tick();
      check("midrst_no_more_beats", beats.size(), 5);
      check("midrst_beats_frozen", beats.size(), nb);
      check("midrst_no_done", dones.size(), 0);

      // Recovery job after the abort.
      clear_mon();
      launch(13'h0600, 14'd3, s0);
      wait_done("recover", 60);
      verify("recover", 13'h0600, 3, 6, s0, 1'b1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
